dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port, word-addressed data memory between the CPU load/store path (port 0) and a loader/debug master (port 1). It grants at most one access per cycle under a valid/ready handshake with bounded-burst round-robin fairness. It drives the memory's address, write-enable and write-data inputs, and returns a registered response to the granted port one cycle later. It sits between the requesters and the data memory instance.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, word-addressed data memory between
// the CPU load/store path (port 0) and a loader/debug master (port 1).
// At most one access is granted per cycle. Under contention the arbiter uses
// round-robin with a bounded burst length. The granted port receives a
// registered response one cycle after acceptance.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake for port N (ready is combinational)
//   reqN_we/addr/wdata        request payload (write enable, word address, data)
//   rspN_valid/rdata          one-cycle response strobe and read data (0 for writes)
//   mem_addr/we/wd            memory drive (zero when there is no grant)
//   mem_rd                    combinational memory read data
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,

  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int unsigned CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  // Arbitration state
  logic                  r_owner;
  logic [CNT_W-1:0]      r_burst_cnt;

  // Registered per-port responses
  logic                  r_rsp0_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_rdata;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp1_rdata;

  // Combinational grant and next-state signals
  logic                  w_gnt_valid;
  logic                  w_gnt_port;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [DATA_WIDTH-1:0] w_rsp_data;
  logic                  w_owner_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  // Grant decision. The owner keeps the bus under contention only while its
  // burst is live (1..MAX_BURST-1). A count of 0 means the burst was broken by
  // an idle cycle, so the other port goes first.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_port  = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        w_gnt_valid = 1'b1;
        if ((r_burst_cnt != '0) && (r_burst_cnt < BURST_MAX)) begin
          w_gnt_port = r_owner;
        end else begin
          w_gnt_port = ~r_owner;
        end
      end else if (req0_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt_port  = 1'b0;
      end else if (req1_valid) begin
        w_gnt_valid = 1'b1;
        w_gnt_port  = 1'b1;
      end
    end
  end

  // Select the granted payload
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_gnt_valid) begin
      if (w_gnt_port) begin
        w_sel_we    = req1_we;
        w_sel_addr  = req1_addr;
        w_sel_wdata = req1_wdata;
      end else begin
        w_sel_we    = req0_we;
        w_sel_addr  = req0_addr;
        w_sel_wdata = req0_wdata;
      end
    end
  end

  assign req0_ready = w_gnt_valid && !w_gnt_port;
  assign req1_ready = w_gnt_valid &&  w_gnt_port;

  // Memory drive is all-zero on no-grant cycles, so mem_we cannot rise without a handshake
  assign mem_addr = DATA_WIDTH'(w_sel_addr);
  assign mem_we   = w_sel_we;
  assign mem_wd   = w_sel_wdata;

  assign w_rsp_data = (w_gnt_valid && !w_sel_we) ? mem_rd : '0;

  // Owner/burst update. The burst saturates at MAX_BURST instead of wrapping.
  always_comb begin
    w_owner_nxt = r_owner;
    w_cnt_nxt   = '0;
    if (w_gnt_valid) begin
      if ((w_gnt_port == r_owner) && (r_burst_cnt != '0)) begin
        w_cnt_nxt = (r_burst_cnt >= BURST_MAX) ? BURST_MAX : (r_burst_cnt + CNT_W'(1));
      end else begin
        w_owner_nxt = w_gnt_port;
        w_cnt_nxt   = CNT_W'(1);
      end
    end
  end

  // State registers. The initial owner is 1, so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= 1'b1;
      r_burst_cnt  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_rdata <= '0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      r_rsp0_valid <= w_gnt_valid && !w_gnt_port;
      r_rsp0_rdata <= (w_gnt_valid && !w_gnt_port) ? w_rsp_data : '0;
      r_rsp1_valid <= w_gnt_valid &&  w_gnt_port;
      r_rsp1_rdata <= (w_gnt_valid &&  w_gnt_port) ? w_rsp_data : '0;
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_rdata = r_rsp1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter, with a
// behavioural word memory attached to the memory port.
module tb_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic [DW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  // Memory model with a side port for preloading
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we)       mem[pl_addr]        <= pl_data;
    else if (mem_we) mem[mem_addr[AW-1:0]] <= mem_wd;
  end
  assign mem_rd = mem[mem_addr[AW-1:0]];

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply this cycle's requests, then wait until mid-cycle for checking
  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #3;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  logic exp_g;
  logic prev_g;

  initial begin
    rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    tick();

    // Preload memory while in reset
    preload(AW'(32'h10), 32'hDEADBEEF);
    preload(AW'(32'h20), 32'hA0A0A0A0);
    preload(AW'(32'h30), 32'hB1B1B1B1);
    preload(AW'(32'h40), 32'h55AA55AA);
    for (int i = 0; i < 8; i++) preload(AW'(32'h200 + i), 32'h1000 + DW'(i));

    // While in reset, requests are refused and nothing is written
    drive(1'b1, 1'b1, AW'(32'h40), 32'hBAD0BAD0, 1'b1, 1'b1, AW'(32'h40), 32'hBAD1BAD1);
    check("rst_ready0", DW'(req0_ready), 32'd0);
    check("rst_ready1", DW'(req1_ready), 32'd0);
    check("rst_mem_we", DW'(mem_we), 32'd0);
    check("rst_rsp0_valid", DW'(rsp0_valid), 32'd0);
    check("rst_rsp0_rdata", rsp0_rdata, 32'd0);
    check("rst_rsp1_valid", DW'(rsp1_valid), 32'd0);
    tick();
    rst = 1'b0;

    // Single read on port 0
    drive(1'b1, 1'b0, AW'(32'h10), '0, 1'b0, 1'b0, '0, '0);
    check("rd_ready0", DW'(req0_ready), 32'd1);
    check("rd_ready1", DW'(req1_ready), 32'd0);
    check("rd_mem_addr", mem_addr, 32'h10);
    check("rd_mem_we", DW'(mem_we), 32'd0);
    tick();
    idle();
    check("rd_rsp0_valid", DW'(rsp0_valid), 32'd1);
    check("rd_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
    check("rd_rsp1_valid", DW'(rsp1_valid), 32'd0);
    check("idle_mem_addr", mem_addr, 32'd0);
    tick();

    // Port 1 writes the top address, then reads it back
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(32'h1FFFF), 32'h12345678);
    check("wr_ready1", DW'(req1_ready), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h0001FFFF);
    check("wr_mem_we", DW'(mem_we), 32'd1);
    check("wr_mem_wd", mem_wd, 32'h12345678);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(32'h1FFFF), '0);
    check("rb_ready1", DW'(req1_ready), 32'd1);
    check("rb_mem_we", DW'(mem_we), 32'd0);
    check("wack_rsp1_valid", DW'(rsp1_valid), 32'd1);
    check("wack_rsp1_rdata", rsp1_rdata, 32'd0);
    tick();
    idle();
    check("rb_rsp1_valid", DW'(rsp1_valid), 32'd1);
    check("rb_rsp1_rdata", rsp1_rdata, 32'h12345678);
    check("rb_rsp0_valid", DW'(rsp0_valid), 32'd0);
    check("rb_rsp0_rdata", rsp0_rdata, 32'd0);
    tick();
    idle();
    check("rsp1_one_cycle", DW'(rsp1_valid), 32'd0);
    tick();

    // Contention from reset: expected grants 0,0,0,0,1,1,1,1,0,0,0,0
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    prev_g = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_g = ((i / 4) % 2) == 1;
      drive(1'b1, 1'b0, AW'(32'h20), '0, 1'b1, 1'b0, AW'(32'h30), '0);
      check($sformatf("cont%0d_ready0", i), DW'(req0_ready), DW'(!exp_g));
      check($sformatf("cont%0d_ready1", i), DW'(req1_ready), DW'(exp_g));
      if (i > 0) begin
        check($sformatf("cont%0d_rsp0", i), DW'(rsp0_valid), DW'(!prev_g));
        check($sformatf("cont%0d_rdata", i), prev_g ? rsp1_rdata : rsp0_rdata,
              prev_g ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
      end
      prev_g = exp_g;
      tick();
    end

    // Idle break: two port-0 grants, one idle cycle, then port 1 goes first
    idle();
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, AW'(32'h20), '0, 1'b0, 1'b0, '0, '0);
      tick();
    end
    idle();
    tick();
    drive(1'b1, 1'b0, AW'(32'h20), '0, 1'b1, 1'b0, AW'(32'h30), '0);
    check("brk_ready1", DW'(req1_ready), 32'd1);
    check("brk_ready0", DW'(req0_ready), 32'd0);
    tick();
    idle();
    tick();

    // Reset mid-stream: read grant, then reset with a pending write on port 1
    drive(1'b1, 1'b0, AW'(32'h10), '0, 1'b0, 1'b0, '0, '0);
    check("mid_ready0", DW'(req0_ready), 32'd1);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(32'h40), 32'hBAD2BAD2);
    check("mid_rst_ready1", DW'(req1_ready), 32'd0);
    check("mid_rst_mem_we", DW'(mem_we), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, AW'(32'h20), '0, 1'b1, 1'b0, AW'(32'h40), '0);
    check("mid_rsp0_dropped", DW'(rsp0_valid), 32'd0);
    check("mid_rsp1_valid", DW'(rsp1_valid), 32'd0);
    check("mid_first_ready0", DW'(req0_ready), 32'd1);
    check("mid_first_ready1", DW'(req1_ready), 32'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(32'h40), '0);
    check("mid_ready1_next", DW'(req1_ready), 32'd1);
    tick();
    idle();
    check("mid_no_write", rsp1_rdata, 32'h55AA55AA);
    tick();

    // Back-to-back reads on port 0 with port 1 idle
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 1'b0, AW'(32'h200 + i), '0, 1'b0, 1'b0, '0, '0);
      else       idle();
      check($sformatf("b2b%0d_ready0", i), DW'(req0_ready), DW'(i < 8));
      check($sformatf("b2b%0d_rsp0_valid", i), DW'(rsp0_valid), DW'(i > 0));
      if (i > 0) check($sformatf("b2b%0d_rsp0_rdata", i), rsp0_rdata, 32'h1000 + DW'(i - 1));
      tick();
    end
    idle();
    check("b2b_done_rsp0", DW'(rsp0_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
